// File: rtl/kmac_msg_packer_pkg.sv
// Shared types and default sizing for the KMAC message packer.
package kmac_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned RATE_BITS_DEF = 1088;
    localparam int unsigned LEN_W_DEF     = 16;
    localparam int unsigned TIMEOUT_DEF   = 4096;
    localparam int unsigned RATE_BYTES    = RATE_BITS_DEF / BYTE_W;
    localparam int unsigned BCNT_W        = $clog2(RATE_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        DRAIN     = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/kmac_msg_packer_if.sv
// Byte-stream valid/ready handshake feeding the packer.
interface kmac_msg_packer_if;
    import kmac_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_data;
    logic              in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/kmac_timeout_cnt.sv
// Clearable, enabled up-counter that saturates at TERM-1 and flags it.
module kmac_timeout_cnt #(
    parameter int unsigned TERM = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic term_c_o
);

    localparam int unsigned W = $clog2(TERM + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign term_c_o = (cnt_q == W'(TERM - 1));

    // Next count: clear wins, otherwise count up to the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !term_c_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/kmac_msg_packer.sv
// Packs a byte stream into one KMAC rate block, starts KMAC and waits for done.
module kmac_msg_packer
    import kmac_pkg::*;
#(
    parameter int unsigned RATE_BITS   = RATE_BITS_DEF,
    parameter int unsigned LEN_W       = LEN_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    kmac_msg_packer_if.slave     in_if,
    output logic [RATE_BITS-1:0] msg_block_o,
    output logic [LEN_W-1:0]     msg_bit_len_o,
    output logic                 kmac_start_o,
    input  logic                 kmac_done_i,
    output logic                 tag_valid_o,
    output logic                 busy_o,
    output logic                 err_overflow_o,
    output logic                 err_timeout_o,
    input  logic                 err_clr_i
);

    localparam int unsigned NBYTES = RATE_BITS / BYTE_W;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
    localparam int unsigned IDX_W  = CNT_W + 3;

    state_e                state_q, state_d;
    logic [RATE_BITS-1:0]  blk_q, blk_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  start_q, start_d;
    logic                  tag_q, tag_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;
    logic                  tmo_q, tmo_d;

    logic                  xfer;
    logic                  tmo_hit;
    logic                  cnt_full;
    logic [CNT_W-1:0]      cnt_inc;
    logic [IDX_W-1:0]      bit_idx;

    // Ready depends on state only and is held low while in reset.
    assign in_if.in_ready = rst_n && ((state_q == IDLE) || (state_q == FILL) || (state_q == DRAIN));
    assign xfer           = in_if.in_valid && in_if.in_ready;
    assign cnt_inc        = cnt_q + CNT_W'(1);
    assign bit_idx        = {cnt_q, 3'b000};
    assign cnt_full       = (cnt_inc == CNT_W'(NBYTES));

    // Wait-for-done watchdog, restarted on the start cycle.
    kmac_timeout_cnt #(
        .TERM (TIMEOUT_CYC)
    ) u_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q == START),
        .en_i     (state_q == WAIT_DONE),
        .term_c_o (tmo_hit)
    );

    // Next-state, block fill and sticky error logic.
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;
        tag_d   = 1'b0;

        if (err_clr_i) begin
            ovf_d = 1'b0;
            tmo_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    blk_d      = '0;
                    blk_d[7:0] = in_if.in_data;
                    cnt_d      = CNT_W'(1);
                    len_d      = LEN_W'({CNT_W'(1), 3'b000});
                    state_d    = in_if.in_last ? START : FILL;
                end
            end
            FILL: begin
                if (xfer) begin
                    blk_d[bit_idx +: 8] = in_if.in_data;
                    cnt_d               = cnt_inc;
                    len_d               = LEN_W'({cnt_inc, 3'b000});
                    if (in_if.in_last) begin
                        state_d = START;
                    end else if (cnt_full) begin
                        ovf_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (xfer && in_if.in_last) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (kmac_done_i) begin
                    tag_d   = 1'b1;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_d = (state_d == START);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            blk_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            tag_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end

    assign msg_block_o    = blk_q;
    assign msg_bit_len_o  = len_q;
    assign kmac_start_o   = start_q;
    assign tag_valid_o    = tag_q;
    assign busy_o         = busy_q;
    assign err_overflow_o = ovf_q;
    assign err_timeout_o  = tmo_q;

endmodule

// File: tb/tb_kmac_msg_packer.sv
// Bench for kmac_msg_packer: directed table, corner sequences, random messages.
module tb_kmac_msg_packer;

    localparam int unsigned RB  = 1088;
    localparam int unsigned LW  = 16;
    localparam int unsigned TMO = 64;
    localparam int unsigned NBY = RB / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kmac_msg_packer_if bus ();

    logic [RB-1:0] msg_block;
    logic [LW-1:0] msg_bit_len;
    logic          kmac_start;
    logic          kmac_done;
    logic          tag_valid;
    logic          busy;
    logic          err_ovf;
    logic          err_tmo;
    logic          err_clr;

    kmac_msg_packer #(
        .RATE_BITS   (RB),
        .LEN_W       (LW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_if          (bus),
        .msg_block_o    (msg_block),
        .msg_bit_len_o  (msg_bit_len),
        .kmac_start_o   (kmac_start),
        .kmac_done_i    (kmac_done),
        .tag_valid_o    (tag_valid),
        .busy_o         (busy),
        .err_overflow_o (err_ovf),
        .err_timeout_o  (err_tmo),
        .err_clr_i      (err_clr)
    );

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    logic [7:0] msg[$];

    typedef struct {
        int unsigned n;
        int unsigned dly;
        int unsigned clr_at;
        int unsigned exp_len;
        bit          exp_ovf;
    } vec_t;

    vec_t tbl[9];

    // Count every cycle the start pulse is seen high.
    always @(negedge clk) begin
        if (kmac_start) start_cnt++;
    end

    task automatic check(input string nm, input logic [RB-1:0] act, input logic [RB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: first min(n, NBY) bytes little-endian, rest zero.
    function automatic logic [RB-1:0] model_block();
        logic [RB-1:0] b;
        b = '0;
        for (int k = 0; k < msg.size() && k < NBY; k++) b[8*k +: 8] = msg[k];
        return b;
    endfunction

    task automatic drive_byte(input logic [7:0] d, input logic last, input logic clr, output logic rdy);
        int budget;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        err_clr      = clr;
        rdy          = bus.in_ready;
        budget       = 0;
        while (!bus.in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.in_ready) check("ready_wait", RB'(0), RB'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        err_clr      = 1'b0;
    endtask

    // dly==0: never answer (timeout); otherwise done is driven dly cycles after start.
    task automatic run_msg(input int unsigned n, input int unsigned dly, input int unsigned clr_at,
                           input logic [LW-1:0] exp_len, input logic exp_ovf, input int unsigned gap_max);
        logic [RB-1:0] exp_blk;
        int s0;
        logic rdy;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_ovf", RB'(err_ovf), RB'(0));
        check("clr_tmo", RB'(err_tmo), RB'(0));
        exp_blk = model_block();
        s0 = start_cnt;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            drive_byte(msg[k], k == n - 1, (k + 1) == clr_at, rdy);
            if (k >= NBY) check("drain_ready", RB'(rdy), RB'(1));
            else if (k == 0) check("first_ready", RB'(rdy), RB'(1));
        end
        @(negedge clk);
        check("start_pulse", RB'(kmac_start), RB'(1));
        check("block", msg_block, exp_blk);
        check("bit_len", RB'(msg_bit_len), RB'(exp_len));
        check("overflow", RB'(err_ovf), RB'(exp_ovf));
        check("busy_start", RB'(busy), RB'(1));
        check("ready_start", RB'(bus.in_ready), RB'(0));
        if (dly == 0) begin
            for (int c = 1; c <= TMO; c++) begin
                @(negedge clk);
                if (c == 1) check("start_one", RB'(kmac_start), RB'(0));
                if (c == TMO) begin
                    check("tmo_early", RB'(err_tmo), RB'(0));
                    check("busy_wait", RB'(busy), RB'(1));
                    check("ready_wait", RB'(bus.in_ready), RB'(0));
                end
            end
            @(negedge clk);
            check("tmo_set", RB'(err_tmo), RB'(1));
            check("tmo_busy", RB'(busy), RB'(0));
            check("tmo_tag", RB'(tag_valid), RB'(0));
            check("tmo_ready", RB'(bus.in_ready), RB'(1));
        end else begin
            for (int c = 1; c < dly; c++) begin
                @(negedge clk);
                if (c == 1) check("start_one", RB'(kmac_start), RB'(0));
                check("ready_wait", RB'(bus.in_ready), RB'(0));
            end
            @(negedge clk);
            kmac_done = 1'b1;
            @(negedge clk);
            kmac_done = 1'b0;
            check("tag_pulse", RB'(tag_valid), RB'(1));
            check("busy_done", RB'(busy), RB'(0));
            check("no_tmo", RB'(err_tmo), RB'(0));
            check("block_held", msg_block, exp_blk);
            @(negedge clk);
            check("tag_one", RB'(tag_valid), RB'(0));
        end
        check("start_count", RB'(start_cnt - s0), RB'(1));
    endtask

    task automatic fill_msg(input int unsigned n);
        msg = {};
        for (int k = 0; k < n; k++) msg.push_back(8'($urandom));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy;
        int s0;
        int unsigned n;
        int unsigned m;

        tbl[0] = '{3,   10,  0,   24,   1'b0};
        tbl[1] = '{1,   3,   0,   8,    1'b0};
        tbl[2] = '{135, 5,   0,   1080, 1'b0};
        tbl[3] = '{136, 10,  0,   1088, 1'b0};
        tbl[4] = '{137, 2,   0,   1088, 1'b1};
        tbl[5] = '{140, 10,  136, 1088, 1'b1};
        tbl[6] = '{5,   0,   0,   40,   1'b0};
        tbl[7] = '{4,   TMO, 0,   32,   1'b0};
        tbl[8] = '{2,   1,   0,   16,   1'b0};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        kmac_done    = 1'b0;
        err_clr      = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", RB'(bus.in_ready), RB'(0));
        check("rst_block", msg_block, RB'(0));
        check("rst_len", RB'(msg_bit_len), RB'(0));
        check("rst_busy", RB'(busy), RB'(0));
        check("rst_start", RB'(kmac_start), RB'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", RB'(bus.in_ready), RB'(1));

        for (int i = 0; i < 9; i++) begin
            if (i == 0) msg = {8'h61, 8'h62, 8'h63};
            else fill_msg(tbl[i].n);
            run_msg(tbl[i].n, tbl[i].dly, tbl[i].clr_at, LW'(tbl[i].exp_len), tbl[i].exp_ovf, 2);
        end

        // Done while idle must not produce a tag.
        @(negedge clk);
        kmac_done = 1'b1;
        @(negedge clk);
        kmac_done = 1'b0;
        check("idle_done_tag", RB'(tag_valid), RB'(0));
        check("idle_done_busy", RB'(busy), RB'(0));

        // Leave a timeout error pending, then reset in the middle of a message.
        fill_msg(3);
        run_msg(3, 0, 0, LW'(24), 1'b0, 1);
        fill_msg(5);
        for (int k = 0; k < 5; k++) drive_byte(msg[k], 1'b0, 1'b0, rdy);
        s0 = start_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", RB'(bus.in_ready), RB'(0));
        check("mid_rst_block", msg_block, RB'(0));
        check("mid_rst_len", RB'(msg_bit_len), RB'(0));
        check("mid_rst_busy", RB'(busy), RB'(0));
        check("mid_rst_tmo", RB'(err_tmo), RB'(0));
        check("mid_rst_ovf", RB'(err_ovf), RB'(0));
        check("mid_rst_tag", RB'(tag_valid), RB'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_start_after_rst", RB'(start_cnt - s0), RB'(0));
        check("ready_after_rst", RB'(bus.in_ready), RB'(1));
        check("block_after_rst", msg_block, RB'(0));
        fill_msg(2);
        run_msg(2, 4, 0, LW'(16), 1'b0, 1);

        // Randomised messages against the reference model.
        for (int r = 0; r < 15; r++) begin
            n = $urandom_range(1, 150);
            m = (n > NBY) ? NBY : n;
            fill_msg(n);
            run_msg(n, $urandom_range(1, 20), 0, LW'(m * 8), n > NBY, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
